// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core
// load/store path (port 0) and the loader/debug DMA (port 1).
// Round-robin arbitration, programmable wait states, a port-0 lock for
// read-modify-write sequences, and an out-of-range flag.
module dmem_arbiter #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  // port 0: core load/store path
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        lock0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  // port 1: loader / debug DMA
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        locked_reg;
  logic        last_reg;
  logic        gnt_reg;
  logic        we_reg;
  logic        err_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;

  // Arbitration decision for the current IDLE cycle
  logic        grant_valid;
  logic        grant_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        out_of_range;

  // Pick the port to serve: lock restricts to port 0, ties go to the port not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (locked_reg) begin
      grant_valid = req0;
      grant_port  = 1'b0;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_port  = ~last_reg;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_port  = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
    end
    sel_we       = grant_port ? we1    : we0;
    sel_addr     = grant_port ? addr1  : addr0;
    sel_wdata    = grant_port ? wdata1 : wdata0;
    out_of_range = (sel_addr[31:2] >= DEPTH_W);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and output decode
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    ack0       = 1'b0;
    err0       = 1'b0;
    rdata0     = 32'h0;
    ack1       = 1'b0;
    err1       = 1'b0;
    rdata1     = 32'h0;
    mem_addr   = addr_reg;
    mem_wdata  = wdata_reg;
    grant      = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) state_next = out_of_range ? DONE : BUSY;
      end
      BUSY: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        // Strobe only on the final access cycle so a store writes once;
        // reset suppresses it immediately so an aborted store never lands.
        mem_we = we_reg && (cnt_reg == 4'd0) && !rst;
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
        if (gnt_reg) begin
          ack1   = 1'b1;
          err1   = err_reg;
          rdata1 = rdata_reg;
        end else begin
          ack0   = 1'b1;
          err0   = err_reg;
          rdata0 = rdata_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction latches, wait counter, round-robin history and lock
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= 4'd0;
      locked_reg <= 1'b0;
      last_reg   <= 1'b1;
      gnt_reg    <= 1'b0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            gnt_reg   <= grant_port;
            we_reg    <= sel_we;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            cnt_reg   <= CNT_INIT;
            err_reg   <= out_of_range;
            rdata_reg <= 32'h0;
          end
        end
        BUSY: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
          else                 rdata_reg <= we_reg ? 32'h0 : mem_rdata;
        end
        DONE: begin
          last_reg <= gnt_reg;
          if (!gnt_reg) locked_reg <= lock0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: port 0 (core load/store path) and port 1 (loader/debug DMA).
- Sits between the requesters and the memory array.
  - Array: word-addressed, combinational read, write on clk edge.
- Arbitrates round-robin, inserts a programmable number of wait states, supports a port-0 lock for read-modify-write sequences (swap/ss style), and flags out-of-range addresses.

Parameters:
- DEPTH, 128, number of 32-bit words in the data memory; valid word index is addr[31:2] < DEPTH.
- WAIT_CYCLES, 1, extra memory access cycles; range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req0  in  1  port 0 request; held with fields stable until ack0
- we0  in  1  port 0 write enable (1 = store, 0 = load)
- addr0  in  32  port 0 byte address
- wdata0  in  32  port 0 store data
- lock0  in  1  port 0 lock; sampled on the ack0 cycle
- ack0  out  1  port 0 one-cycle completion pulse
- err0  out  1  port 0 out-of-range flag; valid with ack0
- rdata0  out  32  port 0 load data; valid with ack0
- req1, we1, addr1, wdata1  in  1/1/32/32  port 1 equivalents
- ack1, err1, rdata1  out  1/1/32  port 1 equivalents
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  32  byte address to memory; memory uses bits [31:2]
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  combinational read data from memory
- busy  out  1  arbiter is not IDLE
- grant  out  1  port currently served; meaningful while busy

Behaviour:
- Reset: all outputs are 0, state = IDLE, cnt = 0, locked = 0, last = 1 (port 0 wins the first tie).
  - rst high forces mem_we = 0 combinationally in that same cycle. No write commits during reset.
  - Reset mid-transaction aborts it: no ack, no write, state returns to IDLE.
- States:
  - IDLE: busy = 0.
    - If locked = 1: only req0 is considered; req1 waits.
    - Else if one request is pending: grant that port.
    - Else if both are pending: grant the port not equal to last.
    - On grant: latch we, addr, wdata and the port number; cnt <= WAIT_CYCLES.
    - If addr[31:2] >= DEPTH: go to DONE with err set. Otherwise go to BUSY.
  - BUSY: mem_en = 1; mem_addr and mem_wdata come from the latched values.
    - mem_we = latched we, asserted only while cnt == 0. This gives exactly one write strobe per transaction.
    - If cnt != 0: cnt <= cnt - 1.
    - If cnt == 0: rdata_q <= mem_rdata (loads only; stores leave rdata_q = 0); go to DONE.
  - DONE: ack of the granted port = 1 for exactly one cycle; err and rdata of that port are driven alongside it.
    - last <= granted port.
    - If the granted port is 0: locked <= lock0.
    - Next state is IDLE.
  - Outside their ack cycle, ackN, errN and rdataN are 0.
- Latency: request seen in IDLE at cycle T leads to ack at T + WAIT_CYCLES + 2; with default 1, ack lands at T+3.
  - Out-of-range: ack + err at T+1; mem_en never asserted.
- Throughput: one transaction per WAIT_CYCLES + 3 cycles.
  - A requester that keeps req high after ack is re-arbitrated in the following IDLE cycle. That is a back-to-back transaction, not an error.
- Simultaneous events:
  - req1 arriving while port 0 is in BUSY waits. No preemption.
  - lock0 = 1 at ack0 starves port 1 until a port-0 transaction completes with lock0 = 0.
- Requester changing fields before its ack: ignored, since values were latched at grant.
- mem_addr and mem_wdata hold their last values when idle. mem_en = 0 and mem_we = 0 outside BUSY.

Test Plan:
- Reset then single load: req0 = 1, we0 = 0, addr0 = 0x20, memory[8] = 8 → ack0 at cycle 3, rdata0 = 8, err0 = 0, mem_we never high.
- Store: req1 = 1, we1 = 1, addr1 = 0x10, wdata1 = 0xDEAD → mem_we high exactly one cycle, with mem_addr = 0x10 and mem_wdata = 0xDEAD; ack1 in the next cycle; a following load from 0x10 returns 0xDEAD.
- Contention: req0 and req1 both held high → grants in order 0, 1, 0, 1; ack spacing 4 cycles with WAIT_CYCLES = 1.
- Lock: port 0 loads with lock0 = 1 while req1 = 1 → port 0's next store is granted before port 1; port 1 is granted only after an ack0 with lock0 = 0.
- Out of range: addr0 = 0x200 (word 128) → ack0 and err0 at cycle 1, rdata0 = 0, mem_en stays 0.
- Reset mid-op: store granted, rst asserted while cnt == 0 → mem_we = 0 that cycle, memory unchanged, no ack, all outputs 0 the next cycle.
